// File: rtl/clock_pkg.sv
// Shared constants and state encoding for the digital clock core.
package clock_pkg;

  localparam int unsigned BCD_W = 4;

  localparam int unsigned FLD_SEC  = 0;
  localparam int unsigned FLD_MIN  = 1;
  localparam int unsigned FLD_HOUR = 2;

  localparam logic [7:0] ALARM_RST_H = 8'h07;
  localparam logic [7:0] ALARM_RST_M = 8'h00;

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    SET_H = 3'd1,
    SET_M = 3'd2,
    SET_S = 3'd3,
    AL_H  = 3'd4,
    AL_M  = 3'd5
  } state_e;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (MODULUS 24 or 60) with increment, clear and wrap carry.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned          MODULUS = 60,
  parameter logic [2*BCD_W-1:0]   RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [2*BCD_W-1:0]   val_o,
  output logic [2*BCD_W-1:0]   nxt_c,
  output logic                 carry_c
);

  localparam logic [BCD_W-1:0] MAX_T = BCD_W'((MODULUS - 1) / 10);
  localparam logic [BCD_W-1:0] MAX_U = BCD_W'((MODULUS - 1) % 10);

  logic [BCD_W-1:0] tens_q, tens_d, units_q, units_d;

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    carry_c = 1'b0;
    if (clr_i) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc_i) begin
      if (tens_q == MAX_T && units_q == MAX_U) begin
        tens_d  = '0;
        units_d = '0;
        carry_c = 1'b1;
      end else if (units_q == BCD_W'(9)) begin
        tens_d  = tens_q + BCD_W'(1);
        units_d = '0;
      end else begin
        units_d = units_q + BCD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q  <= RST_VAL[2*BCD_W-1:BCD_W];
      units_q <= RST_VAL[BCD_W-1:0];
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign val_o = {tens_q, units_q};
  assign nxt_c = {tens_d, units_d};

endmodule

// File: rtl/digital_clock_core.sv
// Timekeeping, alarm and set-mode core feeding the display driver; all display outputs registered.
module digital_clock_core
  import clock_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned HOURLY_SECONDS = 10,
  parameter int unsigned ALARM_SECONDS  = 60
) (
  input  logic        clk,
  input  logic        rst_N,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic        alarm_on,
  output logic [23:0] number_BCD,
  output logic [2:0]  DTube_en,
  output logic [2:0]  Twinkle_en,
  output logic        HOURLY,
  output logic        ALARM
);

  localparam int unsigned PRE_W  = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int unsigned HCNT_W = $clog2(HOURLY_SECONDS + 1);
  localparam int unsigned ACNT_W = $clog2(ALARM_SECONDS + 1);

  state_e              state_q, state_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                hourly_q, hourly_d, alarm_q, alarm_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [ACNT_W-1:0]   acnt_q, acnt_d;
  logic [23:0]         num_q, num_d;
  logic [2:0]          dtube_q, dtube_d, twk_q, twk_d;

  logic sec_tick_c, inc_eff_c, count_en_c, hourly_hit_c, alarm_hit_c;
  logic [7:0] sec_v, min_v, hour_v, alh_v, alm_v;
  logic [7:0] sec_nxt, min_nxt, hour_nxt, alh_nxt, alm_nxt;
  logic sec_cy, min_cy, hour_cy, alh_cy, alm_cy;
  logic unused_c;

  // key_mode takes precedence: a simultaneous key_inc is dropped
  assign sec_tick_c = (pre_q == PRE_W'(CLK_FREQ - 1));
  assign inc_eff_c  = key_inc & ~key_mode;
  assign count_en_c = sec_tick_c & (state_q == RUN || state_q == AL_H || state_q == AL_M);

  bcd_mod_counter #(.MODULUS(60), .RST_VAL(8'h00)) u_sec (
    .clk(clk), .rst_n(rst_N),
    .inc_i(count_en_c), .clr_i(inc_eff_c && state_q == SET_S),
    .val_o(sec_v), .nxt_c(sec_nxt), .carry_c(sec_cy));

  bcd_mod_counter #(.MODULUS(60), .RST_VAL(8'h00)) u_min (
    .clk(clk), .rst_n(rst_N),
    .inc_i((count_en_c && sec_cy) || (inc_eff_c && state_q == SET_M)), .clr_i(1'b0),
    .val_o(min_v), .nxt_c(min_nxt), .carry_c(min_cy));

  bcd_mod_counter #(.MODULUS(24), .RST_VAL(8'h00)) u_hour (
    .clk(clk), .rst_n(rst_N),
    .inc_i((count_en_c && sec_cy && min_cy) || (inc_eff_c && state_q == SET_H)), .clr_i(1'b0),
    .val_o(hour_v), .nxt_c(hour_nxt), .carry_c(hour_cy));

  bcd_mod_counter #(.MODULUS(24), .RST_VAL(ALARM_RST_H)) u_alarm_hour (
    .clk(clk), .rst_n(rst_N),
    .inc_i(inc_eff_c && state_q == AL_H), .clr_i(1'b0),
    .val_o(alh_v), .nxt_c(alh_nxt), .carry_c(alh_cy));

  bcd_mod_counter #(.MODULUS(60), .RST_VAL(ALARM_RST_M)) u_alarm_min (
    .clk(clk), .rst_n(rst_N),
    .inc_i(inc_eff_c && state_q == AL_M), .clr_i(1'b0),
    .val_o(alm_v), .nxt_c(alm_nxt), .carry_c(alm_cy));

  assign unused_c = ^{sec_v, min_v, hour_v, hour_cy, alh_cy, alm_cy};

  // A minute rollover to :00 of the matching alarm minute, or an hour rollover in RUN
  assign hourly_hit_c = sec_tick_c && state_q == RUN && sec_cy && min_cy;
  assign alarm_hit_c  = alarm_on && count_en_c && sec_cy &&
                        hour_nxt == alh_v && min_nxt == alm_v;

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (key_mode) begin
      case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_S;
        SET_S:   state_d = AL_H;
        AL_H:    state_d = AL_M;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    pre_d = sec_tick_c ? '0 : pre_q + PRE_W'(1);
    if (inc_eff_c && state_q == SET_S) pre_d = '0;

    hourly_d = hourly_q;
    hcnt_d   = hcnt_q;
    if (hourly_hit_c) begin
      hourly_d = 1'b1;
      hcnt_d   = HCNT_W'(HOURLY_SECONDS);
    end else if (hourly_q && sec_tick_c) begin
      hcnt_d = hcnt_q - HCNT_W'(1);
      if (hcnt_q == HCNT_W'(1)) hourly_d = 1'b0;
    end

    // A fresh alarm match beats a key pulse arriving in the same cycle
    alarm_d = alarm_q;
    acnt_d  = acnt_q;
    if (alarm_hit_c) begin
      alarm_d = 1'b1;
      acnt_d  = ACNT_W'(ALARM_SECONDS);
    end else if (!alarm_on || key_mode || key_inc) begin
      alarm_d = 1'b0;
    end else if (alarm_q && sec_tick_c) begin
      acnt_d = acnt_q - ACNT_W'(1);
      if (acnt_q == ACNT_W'(1)) alarm_d = 1'b0;
    end
  end

  // Display image is built from next-state values so it tracks state with one register stage
  always_comb begin
    num_d   = {hour_nxt, min_nxt, sec_nxt};
    dtube_d = 3'b111;
    twk_d   = 3'b000;
    case (state_d)
      SET_H: twk_d = 3'b001 << FLD_HOUR;
      SET_M: twk_d = 3'b001 << FLD_MIN;
      SET_S: twk_d = 3'b001 << FLD_SEC;
      AL_H: begin
        num_d   = {alh_nxt, alm_nxt, 8'h00};
        dtube_d = ~(3'b001 << FLD_SEC);
        twk_d   = 3'b001 << FLD_HOUR;
      end
      AL_M: begin
        num_d   = {alh_nxt, alm_nxt, 8'h00};
        dtube_d = ~(3'b001 << FLD_SEC);
        twk_d   = 3'b001 << FLD_MIN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      pre_q    <= '0;
      hourly_q <= 1'b0;
      hcnt_q   <= '0;
      alarm_q  <= 1'b0;
      acnt_q   <= '0;
      num_q    <= 24'h000000;
      dtube_q  <= 3'b111;
      twk_q    <= 3'b000;
    end else begin
      pre_q    <= pre_d;
      hourly_q <= hourly_d;
      hcnt_q   <= hcnt_d;
      alarm_q  <= alarm_d;
      acnt_q   <= acnt_d;
      num_q    <= num_d;
      dtube_q  <= dtube_d;
      twk_q    <= twk_d;
    end
  end

  assign number_BCD = num_q;
  assign DTube_en   = dtube_q;
  assign Twinkle_en = twk_q;
  assign HOURLY     = hourly_q;
  assign ALARM      = alarm_q;

endmodule
